// File: rtl/l2_flush_ctrl.sv
// L2 flush sequencer: merges qualified per-slot flush edges and walks every way/set
// with a one-outstanding handshake. `L2_FLUSH_TIMEOUT_EN enables the per-line stall timeout.
module l2_flush_ctrl #(
    parameter int CPU_MAX        = 4,
    parameter int WAYS_LOG2      = 2,
    parameter int SETS_LOG2      = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CPU_MAX-1:0]   i_flush_l2,
    input  logic [CPU_MAX-1:0]   i_available,
    output logic                 o_req_valid,
    input  logic                 i_req_ready,
    output logic [WAYS_LOG2-1:0] o_req_way,
    output logic [SETS_LOG2-1:0] o_req_set,
    input  logic                 i_resp_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    localparam int IDX_W = WAYS_LOG2 + SETS_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_END} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    logic [CPU_MAX-1:0] flush_q;
    logic               req_edge;
    logic               last_line;
    logic               timeout;
    logic               abort_end;

    // Unavailable slots are masked so stub CPUs can never start a walk.
    assign req_edge  = |(i_flush_l2 & i_available & ~flush_q);
    assign last_line = &idx_q;

    // NOTE: non-blocking assignments for every register so all state updates see pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            flush_q   <= i_flush_l2;
        end
    end

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        if (state_q != ST_IDLE && req_edge) begin
            pending_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (req_edge) begin
                    idx_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_req_ready) begin
                    state_d = ST_WAIT;
                end else if (timeout) begin
                    state_d   = ST_END;
                    pending_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i_resp_valid) begin
                    if (last_line) begin
                        state_d = ST_END;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end else if (timeout) begin
                    state_d   = ST_END;
                    pending_d = 1'b0;
                end
            end
            ST_END: begin
                pending_d = 1'b0;
                // A request arriving in this very cycle restarts too, unless the walk was aborted.
                if ((pending_q || req_edge) && !abort_end) begin
                    idx_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

`ifdef L2_FLUSH_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               error_q;
    logic               abort_q;

    assign timeout   = (state_q == ST_REQ || state_q == ST_WAIT)
                       && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
    assign abort_end = abort_q;
    assign o_error   = error_q;

    always_comb begin
        stall_d = stall_q;
        if (state_d != state_q) begin
            stall_d = '0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_q <= '0;
            error_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            error_q <= error_q | timeout;
            abort_q <= timeout;
        end
    end
`else
    assign timeout   = 1'b0;
    assign abort_end = 1'b0;
    assign o_error   = 1'b0;
`endif

    assign o_req_valid = (state_q == ST_REQ);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_END);
    assign o_req_set   = idx_q[SETS_LOG2-1:0];
    assign o_req_way   = idx_q[IDX_W-1:SETS_LOG2];

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Self-checking bench for l2_flush_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a line-level walk model.
`timescale 1ns/1ps
module tb_l2_flush_ctrl;

    localparam int CPU_MAX        = 4;
    localparam int WAYS_LOG2      = 1;
    localparam int SETS_LOG2      = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int N_LINES        = 1 << (WAYS_LOG2 + SETS_LOG2);
    localparam int N_SETS         = 1 << SETS_LOG2;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [CPU_MAX-1:0]   i_flush_l2;
    logic [CPU_MAX-1:0]   i_available;
    logic                 o_req_valid;
    logic                 i_req_ready;
    logic [WAYS_LOG2-1:0] o_req_way;
    logic [SETS_LOG2-1:0] o_req_set;
    logic                 i_resp_valid;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;

    always #5 i_clk = ~i_clk;

    l2_flush_ctrl #(
        .CPU_MAX(CPU_MAX), .WAYS_LOG2(WAYS_LOG2), .SETS_LOG2(SETS_LOG2),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush_l2(i_flush_l2), .i_available(i_available),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_way(o_req_way),
        .o_req_set(o_req_set), .i_resp_valid(i_resp_valid), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level model: which line is being flushed, whether it has been handed to the
    // L2 yet, whether the completion cycle is showing, and whether a restart is owed.
    logic               m_walking, m_sent, m_finishing, m_again, m_abort, m_err;
    int                 m_line, m_stall;
    logic [CPU_MAX-1:0] m_prev;
    logic               m_rose, m_progress, m_timeout;

    assign m_rose     = |(i_flush_l2 & i_available & ~m_prev);
    assign m_progress = m_sent ? i_resp_valid : i_req_ready;
`ifdef L2_FLUSH_TIMEOUT_EN
    assign m_timeout  = m_walking && !m_progress && (m_stall + 1 == TIMEOUT_CYCLES);
`else
    assign m_timeout  = 1'b0;
`endif

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_walking <= 1'b0; m_sent <= 1'b0; m_finishing <= 1'b0; m_again <= 1'b0;
            m_abort <= 1'b0; m_err <= 1'b0; m_line <= 0; m_stall <= 0; m_prev <= '0;
        end else begin
            m_prev <= i_flush_l2;
            if (m_finishing) begin
                m_finishing <= 1'b0;
                m_again     <= 1'b0;
                m_abort     <= 1'b0;
                m_stall     <= 0;
                m_walking   <= (m_again || m_rose) && !m_abort;
                m_line      <= 0;
                m_sent      <= 1'b0;
            end else if (!m_walking) begin
                if (m_rose) begin
                    m_walking <= 1'b1; m_line <= 0; m_sent <= 1'b0; m_stall <= 0;
                end
            end else begin
                if (m_rose) m_again <= 1'b1;
                if (m_timeout) begin
                    m_err <= 1'b1; m_abort <= 1'b1; m_walking <= 1'b0;
                    m_finishing <= 1'b1; m_again <= 1'b0; m_stall <= 0;
                end else if (m_progress) begin
                    m_stall <= 0;
                    if (!m_sent) begin
                        m_sent <= 1'b1;
                    end else if (m_line == N_LINES - 1) begin
                        m_walking <= 1'b0; m_finishing <= 1'b1;
                    end else begin
                        m_line <= m_line + 1; m_sent <= 1'b0;
                    end
                end else begin
                    m_stall <= m_stall + 1;
                end
            end
        end
    end

    // Per-cycle compare plus transaction recording, sampled on the falling edge.
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int busy_cyc = 0;
    int hs_q[$];

    initial begin
        forever begin
            @(negedge i_clk);
            cyc++;
            check("cyc_valid", o_req_valid, int'(m_walking && !m_sent));
            check("cyc_busy",  o_busy,      int'(m_walking || m_finishing));
            check("cyc_done",  o_done,      int'(m_finishing));
            check("cyc_error", o_error,     int'(m_err));
            if (m_walking && !m_sent) begin
                check("cyc_way", o_req_way, m_line / N_SETS);
                check("cyc_set", o_req_set, m_line % N_SETS);
            end
            if (o_req_valid && i_req_ready) hs_q.push_back(int'(o_req_way) * N_SETS + int'(o_req_set));
            if (o_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (o_busy) busy_cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (o_busy && k < budget) begin
            tick(1);
            k++;
        end
        check(name, o_busy, 0);
    endtask

    task automatic wait_lines(input string name, input int n, input int budget);
        int k = 0;
        while (hs_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, int'(hs_q.size() >= n), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, o_req_valid, 0);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_done"},  o_done, 0);
        check({tag, "_error"}, o_error, 0);
        check({tag, "_way"},   o_req_way, 0);
        check({tag, "_set"},   o_req_set, 0);
    endtask

    int d0, b0, edge_cyc;

    initial begin
        i_rst = 1'b1; i_flush_l2 = '0; i_available = '0; i_req_ready = 1'b0; i_resp_valid = 1'b0;
        tick(3);
        check_reset_outputs("rst");
        i_rst = 1'b0;
        tick(2);

        // Single-slot walk with an always-ready L2: lines 0..7 in order, one done pulse.
        i_req_ready = 1'b1; i_resp_valid = 1'b1; i_available = 4'b0001;
        hs_q.delete(); d0 = done_cnt;
        i_flush_l2 = 4'b0001; edge_cyc = cyc + 1;
        tick(2);
        wait_idle("a_idle", 200);
        tick(2);
        check("a_done_cnt", done_cnt - d0, 1);
        check("a_lines", hs_q.size(), 8);
        foreach (hs_q[i]) check("a_order", hs_q[i], i);
        check("a_done_latency", last_done_cyc - edge_cyc, 17);
        i_flush_l2 = '0;
        tick(2);

        // Request from a slot that is not available: nothing happens.
        i_available = 4'b0011; hs_q.delete(); b0 = busy_cyc;
        i_flush_l2 = 4'b0100;
        tick(10);
        check("b_no_busy", busy_cyc - b0, 0);
        check("b_no_req", hs_q.size(), 0);
        i_flush_l2 = '0;
        tick(2);

        // Two slots rising together merge into one walk.
        hs_q.delete(); d0 = done_cnt;
        i_flush_l2 = 4'b0011;
        tick(2);
        wait_idle("c_idle", 200);
        tick(2);
        check("c_done_cnt", done_cnt - d0, 1);
        check("c_lines", hs_q.size(), 8);
        i_flush_l2 = '0;
        tick(2);

        // Two further edges mid-walk collapse into one restart.
        i_available = 4'b0111; hs_q.delete(); d0 = done_cnt;
        i_flush_l2 = 4'b0001;
        tick(5);
        i_flush_l2 = 4'b0011;
        tick(3);
        i_flush_l2 = 4'b0111;
        tick(2);
        wait_idle("d_idle", 300);
        tick(2);
        check("d_done_cnt", done_cnt - d0, 2);
        check("d_lines", hs_q.size(), 16);
        i_flush_l2 = '0;
        tick(2);

        // L2 back-pressure on line 3: request held stable until accepted.
        i_available = 4'b0001; hs_q.delete(); d0 = done_cnt;
        i_flush_l2 = 4'b0001;
        wait_lines("e_reach_line3", 3, 50);
        i_req_ready = 1'b0;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            check("e_hold_valid", o_req_valid, 1);
            check("e_hold_way", o_req_way, 0);
            check("e_hold_set", o_req_set, 3);
            tick(1);
        end
        i_req_ready = 1'b1;
        wait_idle("e_idle", 200);
        tick(2);
        check("e_lines", hs_q.size(), 8);
        foreach (hs_q[i]) check("e_order", hs_q[i], i);
        check("e_done_cnt", done_cnt - d0, 1);
        i_flush_l2 = '0;
        tick(2);

        // Asynchronous reset while waiting on line 5.
        hs_q.delete();
        i_flush_l2 = 4'b0001;
        wait_lines("f_reach_line5", 6, 50);
        i_resp_valid = 1'b0;
        tick(2);
        d0 = done_cnt;
        #2 i_rst = 1'b1;
        #1 check_reset_outputs("f_async_rst");
        i_flush_l2 = '0;
        tick(2);
        i_rst = 1'b0;
        tick(1);
        check("f_no_done", done_cnt - d0, 0);
        i_resp_valid = 1'b1; hs_q.delete();
        i_flush_l2 = 4'b0001;
        tick(2);
        wait_idle("f_idle", 200);
        tick(2);
        check("f_restart_first", (hs_q.size() > 0) ? hs_q[0] : -1, 0);
        check("f_restart_lines", hs_q.size(), 8);
        check("f_done_cnt", done_cnt - d0, 1);
        i_flush_l2 = '0;
        tick(2);

`ifdef L2_FLUSH_TIMEOUT_EN
        // Stuck response: timeout after 16 waiting cycles, pending edge dropped, error sticky.
        i_available = 4'b0011; i_resp_valid = 1'b0; d0 = done_cnt;
        i_flush_l2 = 4'b0001; edge_cyc = cyc + 1;
        tick(5);
        i_flush_l2 = 4'b0011;
        for (int k = 0; k < 60 && done_cnt == d0; k++) tick(1);
        check("g_timeout_latency", last_done_cyc - edge_cyc, 18);
        tick(3);
        check("g_idle_after", o_busy, 0);
        check("g_error_set", o_error, 1);
        check("g_done_once", done_cnt - d0, 1);
        i_flush_l2 = '0; i_resp_valid = 1'b1;
        tick(1);
        i_flush_l2 = 4'b0001;
        tick(2);
        wait_idle("g_idle", 200);
        check("g_error_sticky", o_error, 1);
        check("g_done_total", done_cnt - d0, 2);
`else
        // Stuck response without the timeout: the block keeps waiting, no error.
        i_resp_valid = 1'b0;
        i_flush_l2 = 4'b0001;
        tick(40);
        check("g_still_busy", o_busy, 1);
        check("g_no_error", o_error, 0);
        check("g_no_valid", o_req_valid, 0);
        i_resp_valid = 1'b1;
        wait_idle("g_idle", 200);
`endif
        i_flush_l2 = '0;
        tick(2);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int s = 0; s < CPU_MAX; s++) begin
                if ($urandom_range(0, 15) == 0) i_flush_l2[s] = ~i_flush_l2[s];
                if ($urandom_range(0, 31) == 0) i_available[s] = ~i_available[s];
            end
            i_req_ready  = ($urandom_range(0, 3) != 0);
            i_resp_valid = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        i_flush_l2 = '0; i_req_ready = 1'b1; i_resp_valid = 1'b1;
        tick(2);
        wait_idle("rand_idle", 400);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
